rat_regfile_mp: RTL

//  Parametrised dual-read/single-write register file for the RAT CPU datapath; next generation of the 8x32 file.

---
 rtl/rat_rf_pkg.sv | 13 +
 rtl/rat_regfile_mp_if.sv | 32 +++
 rtl/rat_rf_clear_ctrl.sv | 59 +++++
 rtl/rat_regfile_mp.sv | 122 ++++++++++++
 4 files changed

// File: rtl/rat_rf_pkg.sv
// Shared types and default geometry for the RAT register file.
// RF_CLEAR encodes as 0, which is also the asynchronous reset state.
package rat_rf_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

  localparam int unsigned RF_DATA_W_DEF = 8;
  localparam int unsigned RF_DEPTH_DEF  = 32;

endpackage

// File: rtl/rat_regfile_mp_if.sv
// Operand/write bundle between decode/control and the RAT register file.
// The master drives addresses, write data and requests; the slave returns operands and status.
interface rat_regfile_mp_if
  import rat_rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W_DEF,
  parameter int unsigned DEPTH  = RF_DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
);

  logic [ADDR_W-1:0] RF_ADDRX;
  logic [ADDR_W-1:0] RF_ADDRY;
  logic [ADDR_W-1:0] RF_ADDRW;
  logic              RF_WR;
  logic [DATA_W-1:0] RF_DIN;
  logic              RF_CLR;
  logic [DATA_W-1:0] RF_DX_OUT;
  logic [DATA_W-1:0] RF_DY_OUT;
  logic              RF_BUSY;
  logic              RF_WR_ERR;

  modport master (
    output RF_ADDRX, RF_ADDRY, RF_ADDRW, RF_WR, RF_DIN, RF_CLR,
    input  RF_DX_OUT, RF_DY_OUT, RF_BUSY, RF_WR_ERR
  );

  modport slave (
    input  RF_ADDRX, RF_ADDRY, RF_ADDRW, RF_WR, RF_DIN, RF_CLR,
    output RF_DX_OUT, RF_DY_OUT, RF_BUSY, RF_WR_ERR
  );

endinterface

// File: rtl/rat_rf_clear_ctrl.sv
// Clear sequencer: after reset or on request, walks every entry once and
// requests a zero write to it; busy for exactly DEPTH cycles.
module rat_rf_clear_ctrl
  import rat_rf_pkg::*;
#(
  parameter int unsigned DEPTH  = RF_DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter stops at the last entry and is parked at 0 while READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_CLEAR: begin
        if (cnt_q == LastAddr) begin
          state_d = RF_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RF_READY: begin
        if (clr_req_i) begin
          state_d = RF_CLEAR;
        end
      end
    endcase
  end

  always_comb begin
    busy_o     = (state_q == RF_CLEAR);
    clr_we_o   = (state_q == RF_CLEAR);
    clr_addr_o = cnt_q;
  end

endmodule

// File: rtl/rat_regfile_mp.sv
// RAT CPU register file: two read ports, one write port, optional write
// bypass and registered reads, with a hardware clear sweep after reset.
module rat_regfile_mp
  import rat_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W_DEF,
  parameter int unsigned DEPTH    = RF_DEPTH_DEF,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned READ_LAT = 0
) (
  input logic             RF_CLK,
  input logic             RF_RST_N,
  rat_regfile_mp_if.slave bus
);

  localparam bit BypassEn = (BYPASS != 0);

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic              in_x, in_y, in_w;
  logic              hit_x, hit_y;
  logic [DATA_W-1:0] rd_x, rd_y;
  logic              wr_err_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  rat_rf_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk_i      (RF_CLK),
    .rst_ni     (RF_RST_N),
    .clr_req_i  (bus.RF_CLR),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // Addresses beyond DEPTH exist only when DEPTH is not a power of two.
  if (DEPTH == (1 << ADDR_W)) begin : g_full_range
    assign in_x = 1'b1;
    assign in_y = 1'b1;
    assign in_w = 1'b1;
  end else begin : g_part_range
    assign in_x = (32'(bus.RF_ADDRX) < DEPTH);
    assign in_y = (32'(bus.RF_ADDRY) < DEPTH);
    assign in_w = (32'(bus.RF_ADDRW) < DEPTH);
  end

  // The sweep owns the write port while busy; user writes are dropped then.
  always_comb begin
    we    = 1'b0;
    waddr = bus.RF_ADDRW;
    wdata = bus.RF_DIN;
    if (clr_we) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = '0;
    end else if (bus.RF_WR && in_w) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge RF_CLK) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign hit_x = BypassEn && bus.RF_WR && (bus.RF_ADDRW == bus.RF_ADDRX);
  assign hit_y = BypassEn && bus.RF_WR && (bus.RF_ADDRW == bus.RF_ADDRY);

  always_comb begin
    rd_x = '0;
    rd_y = '0;
    if (!busy && in_x) begin
      rd_x = hit_x ? bus.RF_DIN : mem_q[bus.RF_ADDRX];
    end
    if (!busy && in_y) begin
      rd_y = hit_y ? bus.RF_DIN : mem_q[bus.RF_ADDRY];
    end
  end

  if (READ_LAT != 0) begin : g_read_reg
    logic [DATA_W-1:0] dx_q, dy_q;

    always_ff @(posedge RF_CLK or negedge RF_RST_N) begin
      if (!RF_RST_N) begin
        dx_q <= '0;
        dy_q <= '0;
      end else begin
        dx_q <= rd_x;
        dy_q <= rd_y;
      end
    end

    assign bus.RF_DX_OUT = dx_q;
    assign bus.RF_DY_OUT = dy_q;
  end else begin : g_read_comb
    assign bus.RF_DX_OUT = rd_x;
    assign bus.RF_DY_OUT = rd_y;
  end

  always_ff @(posedge RF_CLK or negedge RF_RST_N) begin
    if (!RF_RST_N) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= busy && bus.RF_WR;
    end
  end

  assign bus.RF_BUSY   = busy;
  assign bus.RF_WR_ERR = wr_err_q;

endmodule
